pace_calc_seq: RTL and testbench
================================

# pace_calc_seq

Parametrised, multi-cycle successor to the single-cycle pace converter. Accepts a speed sample (knots × 10) from speed_extract over a valid/ready handshake. Computes pace in seconds per statute mile or per kilometre with a shared iterative divider, clamps the result, and drives the MM:SS digits for the 7-segment display. Sits between speed_extract and the display mux.

## Interface
- SPEED_W, 16, width of speed_scaled (knots × 10)
- PACE_W, 16, width of pace_seconds and of the divider datapath
- MIN_SPEED, 6, speeds below this (knots × 10) are treated as stopped
- MAX_PACE, 5999, clamp value in seconds (99:59)
- AVG_LOG2, 2, log2 of averaging window; used only when PACE_AVG_EN is defined
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- speed_valid  in  1  sample strobe
- speed_scaled  in  SPEED_W  speed, knots × 10, unsigned
- unit_sel  in  1  0 = per statute mile, 1 = per km; sampled at acceptance
- in_ready  out  1  high when a sample can be accepted
- pace_seconds  out  PACE_W  clamped pace in seconds
- pace_valid  out  1  one-cycle result pulse
- stopped  out  1  result came from a below-MIN_SPEED sample; updated with pace_valid
- saturated  out  1  quotient exceeded MAX_PACE; updated with pace_valid
- overrun  out  1  sticky; a speed_valid arrived while in_ready = 0
- d0_pace, d1_pace, d2_pace, d3_pace  out  4 each  tens of minutes, ones of minutes, tens of seconds, ones of seconds

## Operation
- Numerators:
  - NUM_MILE = 31284 (36000 / 1.15078)
  - NUM_KM = 19438 (36000 / 1.852)
- FSM states: IDLE → DIV_PACE → DIV_MIN → DIGITS → IDLE.
- in_ready = (state == IDLE). A sample is accepted when speed_valid && in_ready.
- On acceptance:
  - Latch the effective speed and the numerator selected by unit_sel.
  - If effective speed < MIN_SPEED (including 0): set the stopped flag and skip the quotient result. The divider still runs, so latency stays fixed.
- DIV_PACE: restoring division, one quotient bit per cycle, PACE_W cycles. Computes q = numerator / speed.
- Clamp:
  - If stopped, or if q > MAX_PACE: use pace = MAX_PACE.
  - saturated = !stopped && (q > MAX_PACE).
- DIV_MIN: the same divider instance computes minutes = pace / 60 and seconds = remainder, in PACE_W cycles.
- DIGITS: split into digits, d0 = min/10, d1 = min%10, d2 = sec/10, d3 = sec%10. minutes ≤ 99 is guaranteed by the clamp. Register all outputs and pulse pace_valid.
- speed_valid while busy: the sample is dropped, overrun is set to 1 and held until rst, and the computation in flight is unaffected.
- Outputs hold their last values between results.

## Timing
- Reset values:
  - pace_seconds = 0; pace_valid, stopped, saturated, overrun = 0
  - d0..d3 = 4'd1 (display "1111" reset marker)
  - in_ready = 1; state = IDLE
- Latency: if a sample is accepted on edge T, pace_valid is high in the cycle following edge T+2·PACE_W+1. With defaults, the result appears 34 cycles after acceptance.
- in_ready returns high in the same cycle pace_valid is high. A back-to-back sample can be accepted in that cycle.
- rst mid-computation returns the block to IDLE with reset values. No pace_valid is produced for the aborted sample.
- unit_sel changes outside the acceptance cycle have no effect on the sample in flight.

## Configuration
- PACE_AVG_EN defined:
  - Effective speed is the mean of the last 2^AVG_LOG2 accepted samples: running sum >> AVG_LOG2, with the sum register SPEED_W+AVG_LOG2 bits wide.
  - The first accepted sample after rst fills the entire window.
  - The MIN_SPEED comparison uses the averaged value.
- PACE_AVG_EN undefined:
  - Effective speed is the raw sample. No window storage exists, and AVG_LOG2 is ignored.

## Structure
- Package pace_pkg holds:
  - NUM_MILE, NUM_KM
  - UNIT_MILE / UNIT_KM encodings
  - the FSM state enum
  - the SECS_PER_MIN = 60 constant
- Sub-module seq_divider:
  - Parameter W; ports start, dividend, divisor, busy, done, quotient, remainder.
  - A single instance, time-shared between DIV_PACE and DIV_MIN.

## Test plan
- Reset:
  - assert rst 3 cycles → digits 1,1,1,1; pace_seconds 0; pace_valid 0; in_ready 1; overrun 0.
  - second check: assert rst at cycle 10 of a computation → no pace_valid, and outputs return to reset values.
- Mile: speed 100, unit_sel 0 → pace_seconds 312; digits 0,5,1,2; pace_valid exactly 34 cycles after acceptance; stopped 0; saturated 0.
- Km: speed 100, unit_sel 1 → pace_seconds 194; digits 0,3,1,4.
- Boundaries:
  - speed 0 → 5999; digits 9,9,5,9; stopped 1.
  - speed 5 → same outputs; stopped 1.
  - speed 6, mile → 5214; digits 8,6,5,4; saturated 0.
- Overrun: speed 100 accepted, then speed_valid with speed 200 at +5 cycles → single result 312; overrun 1 and held.
- Averaging (PACE_AVG_EN, AVG_LOG2 = 2): samples 100 then 200 (mile) → second result uses 500 >> 2 = 125, giving pace 250 and digits 0,4,1,0.

Source files
------------

// File: rtl/pace_pkg.sv
// Shared constants, unit encodings and FSM state type for the sequential pace converter.
package pace_pkg;

  localparam int NUM_MILE     = 31284;
  localparam int NUM_KM       = 19438;
  localparam int SECS_PER_MIN = 60;

  localparam logic UNIT_MILE = 1'b0;
  localparam logic UNIT_KM   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DIV_PACE,
    DIV_MIN,
    DIGITS
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; the start edge already performs the first step,
// so done pulses W-1 cycles after the start edge with quotient/remainder held until the next start.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          load;
  logic [W-1:0]  src_rem, src_quo, src_dvs;
  logic [W:0]    shifted, diff;
  logic          fits;
  logic [W-1:0]  rem_d, quo_d;

  assign load = start && !busy;

  always_comb begin
    src_rem = load ? '0 : rem_q;
    src_quo = load ? dividend : quo_q;
    src_dvs = load ? divisor : dvs_q;
    shifted = {src_rem, src_quo[W-1]};
    diff    = shifted - {1'b0, src_dvs};
    fits    = shifted >= {1'b0, src_dvs};
    rem_d   = fits ? diff[W-1:0] : shifted[W-1:0];
    quo_d   = {src_quo[W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= divisor;
        cnt_q <= CW'(W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/pace_calc_seq.sv
// Speed (knots x 10) to MM:SS pace via one time-shared divider; fixed 2*PACE_W+1 cycle latency.
// Optional sample averaging is enabled by defining PACE_AVG_EN.
module pace_calc_seq
  import pace_pkg::*;
#(
  parameter int SPEED_W   = 16,
  parameter int PACE_W    = 16,
  parameter int MIN_SPEED = 6,
  parameter int MAX_PACE  = 5999,
  parameter int AVG_LOG2  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              speed_valid,
  input  logic [SPEED_W-1:0] speed_scaled,
  input  logic              unit_sel,
  output logic              in_ready,
  output logic [PACE_W-1:0] pace_seconds,
  output logic              pace_valid,
  output logic              stopped,
  output logic              saturated,
  output logic              overrun,
  output logic [3:0]        d0_pace,
  output logic [3:0]        d1_pace,
  output logic [3:0]        d2_pace,
  output logic [3:0]        d3_pace
);

  state_e            state_q;
  logic              accept;
  logic [SPEED_W-1:0] eff_spd;
  logic              stop_q, sat_q;
  logic [PACE_W-1:0] pace_q, min_q, sec_q;

  logic              div_start, div_busy, div_done;
  logic [PACE_W-1:0] div_dividend, div_divisor, div_quo, div_rem;
  logic              over_max;
  logic [PACE_W-1:0] pace_clamp;

  assign in_ready = (state_q == IDLE);
  assign accept   = speed_valid && in_ready;

`ifdef PACE_AVG_EN
  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = SPEED_W + AVG_LOG2;

  logic [SPEED_W-1:0] win_q [N];
  logic [SW-1:0]      sum_q, sum_d;
  logic               primed_q;

  // The first sample after reset stands in for the whole window.
  always_comb begin
    if (primed_q) sum_d = sum_q - SW'(win_q[N-1]) + SW'(speed_scaled);
    else          sum_d = SW'(speed_scaled) << AVG_LOG2;
    eff_spd = SPEED_W'(sum_d >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= '0;
      primed_q <= 1'b0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
    end else if (accept) begin
      sum_q    <= sum_d;
      primed_q <= 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!primed_q || i == 0) win_q[i] <= speed_scaled;
        else                     win_q[i] <= win_q[i-1];
      end
    end
  end
`else
  assign eff_spd = speed_scaled;
`endif

  assign over_max   = div_quo > PACE_W'(MAX_PACE);
  assign pace_clamp = (stop_q || over_max) ? PACE_W'(MAX_PACE) : div_quo;

  always_comb begin
    div_start    = 1'b0;
    div_dividend = (unit_sel == UNIT_MILE) ? PACE_W'(NUM_MILE) : PACE_W'(NUM_KM);
    div_divisor  = PACE_W'(eff_spd);
    if (state_q == IDLE) begin
      div_start = accept && !div_busy;
    end else if (state_q == DIV_PACE && div_done) begin
      div_start    = 1'b1;
      div_dividend = pace_clamp;
      div_divisor  = PACE_W'(SECS_PER_MIN);
    end
  end

  seq_divider #(.W(PACE_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      stop_q       <= 1'b0;
      sat_q        <= 1'b0;
      pace_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      pace_seconds <= '0;
      pace_valid   <= 1'b0;
      stopped      <= 1'b0;
      saturated    <= 1'b0;
      overrun      <= 1'b0;
      d0_pace      <= 4'd1;
      d1_pace      <= 4'd1;
      d2_pace      <= 4'd1;
      d3_pace      <= 4'd1;
    end else begin
      pace_valid <= 1'b0;
      if (speed_valid && !in_ready) overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            stop_q  <= eff_spd < SPEED_W'(MIN_SPEED);
            state_q <= DIV_PACE;
          end
        end
        DIV_PACE: begin
          if (div_done) begin
            pace_q  <= pace_clamp;
            sat_q   <= !stop_q && over_max;
            state_q <= DIV_MIN;
          end
        end
        DIV_MIN: begin
          if (div_done) begin
            min_q   <= div_quo;
            sec_q   <= div_rem;
            state_q <= DIGITS;
          end
        end
        DIGITS: begin
          pace_seconds <= pace_q;
          stopped      <= stop_q;
          saturated    <= sat_q;
          d0_pace      <= 4'(min_q / PACE_W'(10));
          d1_pace      <= 4'(min_q % PACE_W'(10));
          d2_pace      <= 4'(sec_q / PACE_W'(10));
          d3_pace      <= 4'(sec_q % PACE_W'(10));
          pace_valid   <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pace_calc_seq.sv
// Directed bench for pace_calc_seq: an arithmetic latency/result model checked every cycle,
// plus literal expectations for the individual scenarios.
module tb_pace_calc_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        speed_valid = 1'b0;
  logic [15:0] speed_scaled = '0;
  logic        unit_sel = 1'b0;
  logic        in_ready, pace_valid, stopped, saturated, overrun;
  logic [15:0] pace_seconds;
  logic [3:0]  d0_pace, d1_pace, d2_pace, d3_pace;

  pace_calc_seq dut (
    .clk          (clk),
    .rst          (rst),
    .speed_valid  (speed_valid),
    .speed_scaled (speed_scaled),
    .unit_sel     (unit_sel),
    .in_ready     (in_ready),
    .pace_seconds (pace_seconds),
    .pace_valid   (pace_valid),
    .stopped      (stopped),
    .saturated    (saturated),
    .overrun      (overrun),
    .d0_pace      (d0_pace),
    .d1_pace      (d1_pace),
    .d2_pace      (d2_pace),
    .d3_pace      (d3_pace)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: results are due 33 edges after the accepting edge.
  int m_busy, m_left;
  int exp_pv, exp_pace, exp_stop, exp_sat, exp_ovr;
  int exp_d[4];
  int pend_pace, pend_stop, pend_sat;
  int pend_d[4];
  int hist[$];
  bit primed;

  task automatic compute(input int s, input int u);
    int eff, num, q, mm, ss, sum;
`ifdef PACE_AVG_EN
    if (!primed) begin
      hist = {s, s, s, s};
      primed = 1;
    end else begin
      hist.push_front(s);
      void'(hist.pop_back());
    end
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    eff = sum / 4;
`else
    sum = 0;
    eff = s + sum;
`endif
    num = (u == 0) ? 31284 : 19438;
    pend_stop = (eff < 6) ? 1 : 0;
    q = pend_stop ? 0 : num / eff;
    pend_sat = (!pend_stop && q > 5999) ? 1 : 0;
    pend_pace = (pend_stop || q > 5999) ? 5999 : q;
    mm = pend_pace / 60;
    ss = pend_pace % 60;
    pend_d = '{mm / 10, mm % 10, ss / 10, ss % 10};
  endtask

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      m_busy = 0; m_left = 0; exp_pv = 0; exp_pace = 0; exp_stop = 0; exp_sat = 0; exp_ovr = 0;
      exp_d = '{1, 1, 1, 1};
      primed = 0;
      hist.delete();
    end else begin
      acc = speed_valid && (m_busy == 0);
      exp_pv = 0;
      if (speed_valid && m_busy != 0) exp_ovr = 1;
      if (m_busy != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          exp_pv = 1;
          exp_pace = pend_pace; exp_stop = pend_stop; exp_sat = pend_sat; exp_d = pend_d;
        end
      end
      if (acc) begin
        compute(int'(speed_scaled), int'(unit_sel));
        m_busy = 1;
        m_left = 33;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pace_valid", pace_valid, exp_pv);
      check("in_ready", in_ready, (m_busy == 0) ? 1 : 0);
      check("overrun", overrun, exp_ovr);
      check("pace_seconds", pace_seconds, exp_pace);
      check("stopped", stopped, exp_stop);
      check("saturated", saturated, exp_sat);
      check("d0", d0_pace, exp_d[0]);
      check("d1", d1_pace, exp_d[1]);
      check("d2", d2_pace, exp_d[2]);
      check("d3", d3_pace, exp_d[3]);
    end
  end

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Drive a sample in the current cycle; unit_sel is flipped afterwards to show it is not re-sampled.
  task automatic send_now(input int s, input int u);
    speed_valid = 1'b1; speed_scaled = 16'(s); unit_sel = u[0];
    @(negedge clk);
    speed_valid = 1'b0; unit_sel = ~u[0];
  endtask

  task automatic send(input int s, input int u);
    @(negedge clk);
    send_now(s, u);
  endtask

  task automatic wait_pv(input int maxc, output int lat);
    lat = 1;
    while (pace_valid !== 1'b1 && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
    if (pace_valid !== 1'b1) check("result_timeout", 0, 1);
  endtask

  task automatic expect_res(input string tag, input int p, input int a, input int b, input int c,
                            input int d, input int stp);
    check({tag, "_pace"}, pace_seconds, p);
    check({tag, "_digits"}, {d0_pace, d1_pace, d2_pace, d3_pace}, {4'(a), 4'(b), 4'(c), 4'(d)});
    check({tag, "_stopped"}, stopped, stp);
    check({tag, "_saturated"}, saturated, 0);
  endtask

  initial begin
    int lat, seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    check("rst_digits", {d0_pace, d1_pace, d2_pace, d3_pace}, 16'h1111);
    check("rst_pace", pace_seconds, 0);
    check("rst_pv", pace_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    send(100, 0);
    wait_pv(60, lat);
    check("mile_latency", lat, 34);
    expect_res("mile", 312, 0, 5, 1, 2, 0);

    send_now(100, 1);
    wait_pv(60, lat);
    check("km_b2b_latency", lat, 34);
    expect_res("km", 194, 0, 3, 1, 4, 0);

    pulse_reset(); send(0, 0); wait_pv(60, lat);
    expect_res("zero", 5999, 9, 9, 5, 9, 1);

    pulse_reset(); send(5, 1); wait_pv(60, lat);
    expect_res("five", 5999, 9, 9, 5, 9, 1);

    pulse_reset(); send(6, 0); wait_pv(60, lat);
    expect_res("six", 5214, 8, 6, 5, 4, 0);

    pulse_reset(); send(100, 0);
    repeat (4) @(negedge clk);
    send_now(200, 0);
    wait_pv(60, lat);
    expect_res("ovr", 312, 0, 5, 1, 2, 0);
    check("ovr_flag", overrun, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (pace_valid === 1'b1) seen++;
    end
    check("ovr_single_result", seen, 0);
    check("ovr_held", overrun, 1);

    pulse_reset(); send(100, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_digits", {d0_pace, d1_pace, d2_pace, d3_pace}, 16'h1111);
    check("abort_pace", pace_seconds, 0);
    check("abort_overrun", overrun, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (pace_valid === 1'b1) seen++;
    end
    check("abort_no_pv", seen, 0);

`ifdef PACE_AVG_EN
    pulse_reset(); send(100, 0); wait_pv(60, lat);
    expect_res("avg1", 312, 0, 5, 1, 2, 0);
    send(200, 0); wait_pv(60, lat);
    expect_res("avg2", 250, 0, 4, 1, 0, 0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
